// File: rtl/tcu_uop_sequencer_if.sv
// tcu_uop_sequencer_if: WMMA instruction input and TCU uop output bundle.
// master = sequencer side (consumes instructions, produces uops);
// slave  = environment side (issue stage + TCU execute unit).
interface tcu_uop_sequencer_if #(
  parameter int unsigned M_STEPS      = 2,
  parameter int unsigned N_STEPS      = 4,
  parameter int unsigned K_STEPS      = 4,
  parameter int unsigned A_SUB_BLOCKS = 1,
  parameter int unsigned B_SUB_BLOCKS = 2,
  parameter int unsigned WID_W        = 4
);
  localparam int unsigned SM_W   = (M_STEPS > 1) ? $clog2(M_STEPS) : 1;
  localparam int unsigned SN_W   = (N_STEPS > 1) ? $clog2(N_STEPS) : 1;
  localparam int unsigned SK_W   = (K_STEPS > 1) ? $clog2(K_STEPS) : 1;
  localparam int unsigned ASEL_W = (A_SUB_BLOCKS > 1) ? $clog2(A_SUB_BLOCKS) : 1;
  localparam int unsigned BSEL_W = (B_SUB_BLOCKS > 1) ? $clog2(B_SUB_BLOCKS) : 1;

  // instruction side
  logic              in_valid;
  logic              in_ready;
  logic [WID_W-1:0]  in_wid;
  logic [3:0]        in_fmt_s;
  logic [3:0]        in_fmt_d;

  // uop side
  logic              out_valid;
  logic              out_ready;
  logic [WID_W-1:0]  out_wid;
  logic [3:0]        out_fmt_s;
  logic [3:0]        out_fmt_d;
  logic [SM_W-1:0]   out_step_m;
  logic [SN_W-1:0]   out_step_n;
  logic [SK_W-1:0]   out_step_k;
  logic [4:0]        out_rs1;
  logic [4:0]        out_rs2;
  logic [4:0]        out_rs3;
  logic [ASEL_W-1:0] out_asel;
  logic [BSEL_W-1:0] out_bsel;
  logic              out_first;
  logic              out_last;

  modport master (
    input  in_valid, in_wid, in_fmt_s, in_fmt_d, out_ready,
    output in_ready, out_valid, out_wid, out_fmt_s, out_fmt_d,
           out_step_m, out_step_n, out_step_k,
           out_rs1, out_rs2, out_rs3, out_asel, out_bsel,
           out_first, out_last
  );

  modport slave (
    output in_valid, in_wid, in_fmt_s, in_fmt_d, out_ready,
    input  in_ready, out_valid, out_wid, out_fmt_s, out_fmt_d,
           out_step_m, out_step_n, out_step_k,
           out_rs1, out_rs2, out_rs3, out_asel, out_bsel,
           out_first, out_last
  );
endinterface

// File: rtl/tcu_uop_sequencer.sv
// tcu_uop_sequencer: expands one WMMA instruction into M*N*K TCU micro-ops
// (k innermost, then n, then m), each carrying step indices, A/B/C register
// selects and A/B sub-block selects. All outputs are registered.
// Optional feature macro: TCU_UOP_PERF_EN adds perf_uops / perf_stalls counters.
module tcu_uop_sequencer #(
  parameter int unsigned M_STEPS      = 2,
  parameter int unsigned N_STEPS      = 4,
  parameter int unsigned K_STEPS      = 4,
  parameter int unsigned A_SUB_BLOCKS = 1,
  parameter int unsigned B_SUB_BLOCKS = 2,
  parameter int unsigned RA           = 0,
  parameter int unsigned RB           = 10,
  parameter int unsigned RC           = 24,
  parameter int unsigned WID_W        = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  tcu_uop_sequencer_if.master  io
`ifdef TCU_UOP_PERF_EN
  ,
  output logic [31:0]          perf_uops,
  output logic [31:0]          perf_stalls
`endif
);

  localparam int unsigned SM_W   = (M_STEPS > 1) ? $clog2(M_STEPS) : 1;
  localparam int unsigned SN_W   = (N_STEPS > 1) ? $clog2(N_STEPS) : 1;
  localparam int unsigned SK_W   = (K_STEPS > 1) ? $clog2(K_STEPS) : 1;
  localparam int unsigned ASEL_W = (A_SUB_BLOCKS > 1) ? $clog2(A_SUB_BLOCKS) : 1;
  localparam int unsigned BSEL_W = (B_SUB_BLOCKS > 1) ? $clog2(B_SUB_BLOCKS) : 1;

  // Highest register number each select can reach.
  localparam int unsigned RS1_MAX = RA + (M_STEPS * K_STEPS - 1) / A_SUB_BLOCKS;
  localparam int unsigned RS2_MAX = RB + (N_STEPS * K_STEPS - 1) / B_SUB_BLOCKS;
  localparam int unsigned RS3_MAX = RC + M_STEPS * N_STEPS - 1;

  // Reject parameter sets that would overflow 5-bit register numbers.
  if (RS1_MAX > 31 || RS2_MAX > 31 || RS3_MAX > 31) begin : g_reg_overflow
    $error("tcu_uop_sequencer: register numbering exceeds 5 bits");
  end
  if (M_STEPS < 1 || N_STEPS < 1 || K_STEPS < 1) begin : g_bad_steps
    $error("tcu_uop_sequencer: step counts must be at least 1");
  end

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [SM_W-1:0]    m_q, m_d;
  logic [SN_W-1:0]    n_q, n_d;
  logic [SK_W-1:0]    k_q, k_d;
  logic [WID_W-1:0]   wid_q, wid_d;
  logic [3:0]         src_fmt_q, src_fmt_d;
  logic [3:0]         dst_fmt_q, dst_fmt_d;
  logic               valid_q, valid_d;
  logic               ready_q, ready_d;
  logic [4:0]         rs1_q, rs1_d;
  logic [4:0]         rs2_q, rs2_d;
  logic [4:0]         rs3_q, rs3_d;
  logic [ASEL_W-1:0]  asel_q, asel_d;
  logic [BSEL_W-1:0]  bsel_q, bsel_d;
  logic               first_q, first_d;
  logic               last_q, last_d;

  logic               m_max, n_max, k_max;
  logic [31:0]        a_idx, b_idx, c_idx;

  assign m_max = (m_q == SM_W'(M_STEPS - 1));
  assign n_max = (n_q == SN_W'(N_STEPS - 1));
  assign k_max = (k_q == SK_W'(K_STEPS - 1));

  // Next state and step counters: accept in IDLE, advance k/n/m on each accepted uop.
  always_comb begin
    state_d   = state_q;
    m_d       = m_q;
    n_d       = n_q;
    k_d       = k_q;
    wid_d     = wid_q;
    src_fmt_d = src_fmt_q;
    dst_fmt_d = dst_fmt_q;
    case (state_q)
      IDLE: begin
        if (io.in_valid && ready_q) begin
          wid_d     = io.in_wid;
          src_fmt_d = io.in_fmt_s;
          dst_fmt_d = io.in_fmt_d;
          m_d       = '0;
          n_d       = '0;
          k_d       = '0;
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        if (io.out_ready) begin
          if (k_max) begin
            k_d = '0;
            if (n_max) begin
              n_d = '0;
              if (m_max) begin
                m_d     = '0;
                state_d = IDLE;
              end else begin
                m_d = m_q + SM_W'(1);
              end
            end else begin
              n_d = n_q + SN_W'(1);
            end
          end else begin
            k_d = k_q + SK_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Uop payload for the next cycle, derived from the next counter values.
  always_comb begin
    a_idx   = 32'(m_d) * K_STEPS + 32'(k_d);
    b_idx   = 32'(n_d) * K_STEPS + 32'(k_d);
    c_idx   = 32'(m_d) * N_STEPS + 32'(n_d);
    valid_d = (state_d == ISSUE);
    ready_d = (state_d == IDLE);
    rs1_d   = 5'(RA + a_idx / A_SUB_BLOCKS);
    rs2_d   = 5'(RB + b_idx / B_SUB_BLOCKS);
    rs3_d   = 5'(RC + c_idx);
    asel_d  = ASEL_W'(a_idx % A_SUB_BLOCKS);
    bsel_d  = BSEL_W'(b_idx % B_SUB_BLOCKS);
    first_d = valid_d && (m_d == '0) && (n_d == '0) && (k_d == '0);
    last_d  = valid_d && (m_d == SM_W'(M_STEPS - 1)) &&
              (n_d == SN_W'(N_STEPS - 1)) && (k_d == SK_W'(K_STEPS - 1));
  end

  // State, counter and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      m_q       <= '0;
      n_q       <= '0;
      k_q       <= '0;
      wid_q     <= '0;
      src_fmt_q <= '0;
      dst_fmt_q <= '0;
      valid_q   <= 1'b0;
      ready_q   <= 1'b0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      rs3_q     <= '0;
      asel_q    <= '0;
      bsel_q    <= '0;
      first_q   <= 1'b0;
      last_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      m_q       <= m_d;
      n_q       <= n_d;
      k_q       <= k_d;
      wid_q     <= wid_d;
      src_fmt_q <= src_fmt_d;
      dst_fmt_q <= dst_fmt_d;
      valid_q   <= valid_d;
      ready_q   <= ready_d;
      rs1_q     <= rs1_d;
      rs2_q     <= rs2_d;
      rs3_q     <= rs3_d;
      asel_q    <= asel_d;
      bsel_q    <= bsel_d;
      first_q   <= first_d;
      last_q    <= last_d;
    end
  end

  assign io.in_ready   = ready_q;
  assign io.out_valid  = valid_q;
  assign io.out_wid    = wid_q;
  assign io.out_fmt_s  = src_fmt_q;
  assign io.out_fmt_d  = dst_fmt_q;
  assign io.out_step_m = m_q;
  assign io.out_step_n = n_q;
  assign io.out_step_k = k_q;
  assign io.out_rs1    = rs1_q;
  assign io.out_rs2    = rs2_q;
  assign io.out_rs3    = rs3_q;
  assign io.out_asel   = asel_q;
  assign io.out_bsel   = bsel_q;
  assign io.out_first  = first_q;
  assign io.out_last   = last_q;

`ifdef TCU_UOP_PERF_EN
  logic [31:0] perf_uops_q, perf_uops_d;
  logic [31:0] perf_stalls_q, perf_stalls_d;

  // Count accepted uops and backpressure cycles (both wrap naturally).
  always_comb begin
    perf_uops_d   = perf_uops_q + 32'(valid_q && io.out_ready);
    perf_stalls_d = perf_stalls_q + 32'(valid_q && !io.out_ready);
  end

  // Performance counter registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_uops_q   <= '0;
      perf_stalls_q <= '0;
    end else begin
      perf_uops_q   <= perf_uops_d;
      perf_stalls_q <= perf_stalls_d;
    end
  end

  assign perf_uops   = perf_uops_q;
  assign perf_stalls = perf_stalls_q;
`endif

endmodule

// File: tb/tb_tcu_uop_sequencer.sv
// tb_tcu_uop_sequencer: table vectors, directed corner sequences and random
// traffic against a queue-based reference model of the uop stream.
module tb_tcu_uop_sequencer;
  localparam int unsigned M_STEPS = 2;
  localparam int unsigned N_STEPS = 4;
  localparam int unsigned K_STEPS = 4;
  localparam int unsigned A_SB    = 1;
  localparam int unsigned B_SB    = 2;
  localparam int unsigned RA      = 0;
  localparam int unsigned RB      = 10;
  localparam int unsigned RC      = 24;
  localparam int unsigned WID_W   = 4;
  localparam int unsigned NUOP    = M_STEPS * N_STEPS * K_STEPS;
  localparam int unsigned SM_W    = (M_STEPS > 1) ? $clog2(M_STEPS) : 1;
  localparam int unsigned SN_W    = (N_STEPS > 1) ? $clog2(N_STEPS) : 1;
  localparam int unsigned SK_W    = (K_STEPS > 1) ? $clog2(K_STEPS) : 1;
  localparam int unsigned AS_W    = (A_SB > 1) ? $clog2(A_SB) : 1;
  localparam int unsigned BS_W    = (B_SB > 1) ? $clog2(B_SB) : 1;

  typedef struct packed {
    logic [WID_W-1:0] wid;
    logic [3:0]       fs;
    logic [3:0]       fd;
    logic [SM_W-1:0]  m;
    logic [SN_W-1:0]  n;
    logic [SK_W-1:0]  k;
    logic [4:0]       rs1;
    logic [4:0]       rs2;
    logic [4:0]       rs3;
    logic [AS_W-1:0]  asel;
    logic [BS_W-1:0]  bsel;
    logic             first;
    logic             last;
  } uop_t;

  typedef struct {
    int unsigned idx;
    int unsigned m, n, k;
    int unsigned rs1, rs2, rs3, bsel;
    bit          first, last;
  } vec_t;

  logic clk;
  logic reset_n;
  always #5 clk = ~clk;

  tcu_uop_sequencer_if #(.M_STEPS(M_STEPS), .N_STEPS(N_STEPS), .K_STEPS(K_STEPS),
                         .A_SUB_BLOCKS(A_SB), .B_SUB_BLOCKS(B_SB), .WID_W(WID_W)) bus ();
  tcu_uop_sequencer_if #(.M_STEPS(1), .N_STEPS(1), .K_STEPS(1),
                         .A_SUB_BLOCKS(A_SB), .B_SUB_BLOCKS(B_SB), .WID_W(WID_W)) bus1 ();

`ifdef TCU_UOP_PERF_EN
  logic [31:0] perf_uops, perf_stalls, perf1_uops, perf1_stalls;
`endif

  tcu_uop_sequencer #(.M_STEPS(M_STEPS), .N_STEPS(N_STEPS), .K_STEPS(K_STEPS),
                      .A_SUB_BLOCKS(A_SB), .B_SUB_BLOCKS(B_SB),
                      .RA(RA), .RB(RB), .RC(RC), .WID_W(WID_W)) dut (
    .clk(clk), .reset_n(reset_n), .io(bus)
`ifdef TCU_UOP_PERF_EN
    , .perf_uops(perf_uops), .perf_stalls(perf_stalls)
`endif
  );

  tcu_uop_sequencer #(.M_STEPS(1), .N_STEPS(1), .K_STEPS(1),
                      .A_SUB_BLOCKS(A_SB), .B_SUB_BLOCKS(B_SB),
                      .RA(RA), .RB(RB), .RC(RC), .WID_W(WID_W)) dut1 (
    .clk(clk), .reset_n(reset_n), .io(bus1)
`ifdef TCU_UOP_PERF_EN
    , .perf_uops(perf1_uops), .perf_stalls(perf1_stalls)
`endif
  );

  int   total = 0;
  int   bad   = 0;
  uop_t exp_q[$];
  uop_t cap[64];
  int   cap_n = 0;
  int   vcyc  = 0;
  int unsigned mdl_uops   = 0;
  int unsigned mdl_stalls = 0;
  vec_t tbl[7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: enumerate the instruction's uops straight from the index formulas.
  task automatic push_instr(input logic [WID_W-1:0] w, input logic [3:0] fs, input logic [3:0] fd);
    uop_t u;
    int unsigned m, n, k, a, b;
    for (int i = 0; i < int'(NUOP); i++) begin
      m = i / (N_STEPS * K_STEPS);
      n = (i / K_STEPS) % N_STEPS;
      k = i % K_STEPS;
      a = m * K_STEPS + k;
      b = n * K_STEPS + k;
      u.wid   = w;
      u.fs    = fs;
      u.fd    = fd;
      u.m     = SM_W'(m);
      u.n     = SN_W'(n);
      u.k     = SK_W'(k);
      u.rs1   = 5'(RA + a / A_SB);
      u.rs2   = 5'(RB + b / B_SB);
      u.rs3   = 5'(RC + m * N_STEPS + n);
      u.asel  = AS_W'(a % A_SB);
      u.bsel  = BS_W'(b % B_SB);
      u.first = (i == 0);
      u.last  = (i == int'(NUOP) - 1);
      exp_q.push_back(u);
    end
  endtask

  function automatic uop_t dut_uop();
    uop_t u;
    u.wid   = bus.out_wid;
    u.fs    = bus.out_fmt_s;
    u.fd    = bus.out_fmt_d;
    u.m     = bus.out_step_m;
    u.n     = bus.out_step_n;
    u.k     = bus.out_step_k;
    u.rs1   = bus.out_rs1;
    u.rs2   = bus.out_rs2;
    u.rs3   = bus.out_rs3;
    u.asel  = bus.out_asel;
    u.bsel  = bus.out_bsel;
    u.first = bus.out_first;
    u.last  = bus.out_last;
    return u;
  endfunction

  // One cycle: compare DUT against model, then advance model by the handshakes at the next edge.
  task automatic step();
    chk("out_valid", bus.out_valid, exp_q.size() > 0);
    chk("in_ready", bus.in_ready, exp_q.size() == 0);
    if (exp_q.size() > 0) chk("uop", dut_uop(), exp_q[0]);
    if (bus.out_valid) vcyc++;
    if (bus.out_valid && bus.out_ready && cap_n < 64) begin
      cap[cap_n] = dut_uop();
      cap_n++;
    end
    if (exp_q.size() > 0) begin
      if (bus.out_ready) begin
        void'(exp_q.pop_front());
        mdl_uops++;
      end else begin
        mdl_stalls++;
      end
    end else if (bus.in_valid) begin
      push_instr(bus.in_wid, bus.in_fmt_s, bus.in_fmt_d);
    end
    @(negedge clk);
  endtask

  task automatic drain(input string name, input int budget, input bit toggle);
    int n;
    bit ph;
    n  = 0;
    ph = 1'b1;
    while (exp_q.size() > 0 && n < budget) begin
      if (toggle) begin
        bus.out_ready = ph;
        ph = !ph;
      end
      step();
      n++;
    end
    if (exp_q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL %s: timeout, %0d uops still pending", name, exp_q.size());
    end
  endtask

  task automatic check_perf(input string name);
`ifdef TCU_UOP_PERF_EN
    chk({name, "_perf_uops"}, perf_uops, mdl_uops);
    chk({name, "_perf_stalls"}, perf_stalls, mdl_stalls);
`else
    if (name.len() < 0) $display("%s", name);
`endif
  endtask

  initial begin
    // idx, m, n, k, rs1, rs2, rs3, bsel, first, last
    tbl[0] = '{0,  0, 0, 0, 0, 10, 24, 0, 1'b1, 1'b0};
    tbl[1] = '{1,  0, 0, 1, 1, 10, 24, 1, 1'b0, 1'b0};
    tbl[2] = '{5,  0, 1, 1, 1, 12, 25, 1, 1'b0, 1'b0};
    tbl[3] = '{15, 0, 3, 3, 3, 17, 27, 1, 1'b0, 1'b0};
    tbl[4] = '{16, 1, 0, 0, 4, 10, 28, 0, 1'b0, 1'b0};
    tbl[5] = '{27, 1, 2, 3, 7, 15, 30, 1, 1'b0, 1'b0};
    tbl[6] = '{31, 1, 3, 3, 7, 17, 31, 1, 1'b0, 1'b1};

    clk = 1'b0;
    reset_n = 1'b0;
    bus.in_valid = 1'b0;  bus.in_wid = '0;  bus.in_fmt_s = '0;  bus.in_fmt_d = '0;
    bus.out_ready = 1'b1;
    bus1.in_valid = 1'b0; bus1.in_wid = '0; bus1.in_fmt_s = '0; bus1.in_fmt_d = '0;
    bus1.out_ready = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_in_ready", bus.in_ready, 1'b0);
    chk("rst_rs2", bus.out_rs2, 5'd0);
    chk("rst_first", bus.out_first, 1'b0);
    chk("rst1_out_valid", bus1.out_valid, 1'b0);
    check_perf("rst");
    reset_n = 1'b1;
    @(negedge clk);
    step();

    // Degenerate 1x1x1 instance: single uop with first=last
    bus1.in_valid = 1'b1; bus1.in_wid = 4'd6; bus1.in_fmt_s = 4'd3; bus1.in_fmt_d = 4'd4;
    @(negedge clk);
    bus1.in_valid = 1'b0;
    chk("one_valid", bus1.out_valid, 1'b1);
    chk("one_first_last", {bus1.out_first, bus1.out_last}, 2'b11);
    chk("one_regs", {bus1.out_rs1, bus1.out_rs2, bus1.out_rs3}, {5'(RA), 5'(RB), 5'(RC)});
    chk("one_wid", bus1.out_wid, 4'd6);
    @(negedge clk);
    chk("one_done_valid", bus1.out_valid, 1'b0);
    chk("one_done_ready", bus1.in_ready, 1'b1);

    // Single instruction, out_ready=1: table of selected uops
    bus.in_valid = 1'b1; bus.in_wid = 4'd3; bus.in_fmt_s = 4'd2; bus.in_fmt_d = 4'd7;
    cap_n = 0; vcyc = 0;
    step();
    bus.in_valid = 1'b0;
    drain("single", 40, 1'b0);
    step();
    chk("single_count", cap_n, NUOP);
    chk("single_valid_cycles", vcyc, NUOP);
    for (int i = 0; i < 7; i++) begin
      uop_t c;
      c = cap[tbl[i].idx];
      chk($sformatf("tbl%0d_steps", tbl[i].idx), {c.m, c.n, c.k},
          {SM_W'(tbl[i].m), SN_W'(tbl[i].n), SK_W'(tbl[i].k)});
      chk($sformatf("tbl%0d_regs", tbl[i].idx), {c.rs1, c.rs2, c.rs3},
          {5'(tbl[i].rs1), 5'(tbl[i].rs2), 5'(tbl[i].rs3)});
      chk($sformatf("tbl%0d_bsel", tbl[i].idx), c.bsel, BS_W'(tbl[i].bsel));
      chk($sformatf("tbl%0d_first_last", tbl[i].idx), {c.first, c.last},
          {tbl[i].first, tbl[i].last});
    end
    check_perf("single");

    // out_ready toggling: 32 uops over 63 valid cycles
    bus.in_valid = 1'b1; bus.in_wid = 4'd9; bus.in_fmt_s = 4'd13; bus.in_fmt_d = 4'd0;
    vcyc = 0;
    step();
    bus.in_valid = 1'b0;
    drain("toggle", 100, 1'b1);
    bus.out_ready = 1'b1;
    chk("toggle_valid_cycles", vcyc, 2 * NUOP - 1);
    check_perf("toggle");

    // Second instruction held during ISSUE: accepted only after the bubble
    bus.in_valid = 1'b1; bus.in_wid = 4'd3; bus.in_fmt_s = 4'd1; bus.in_fmt_d = 4'd1;
    step();
    bus.in_wid = 4'd5; bus.in_fmt_s = 4'd1; bus.in_fmt_d = 4'd9;
    drain("held_first", 40, 1'b0);
    step();
    bus.in_valid = 1'b0;
    chk("held_second_wid", bus.out_wid, 4'd5);
    chk("held_second_first", bus.out_first, 1'b1);
    drain("held_second", 40, 1'b0);
    step();

    // Reset asserted mid-ISSUE after uop 10
    bus.in_valid = 1'b1; bus.in_wid = 4'd2; bus.in_fmt_s = 4'd4; bus.in_fmt_d = 4'd5;
    cap_n = 0;
    step();
    bus.in_valid = 1'b0;
    for (int n = 0; n < 50 && cap_n < 11; n++) step();
    chk("midrst_uops_before", cap_n, 11);
    #2 reset_n = 1'b0;
    #1;
    chk("midrst_out_valid", bus.out_valid, 1'b0);
    chk("midrst_in_ready", bus.in_ready, 1'b0);
    exp_q.delete();
    mdl_uops = 0;
    mdl_stalls = 0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    step();
    bus.in_valid = 1'b1; bus.in_wid = 4'd11; bus.in_fmt_s = 4'd8; bus.in_fmt_d = 4'd6;
    step();
    bus.in_valid = 1'b0;
    chk("postrst_first", bus.out_first, 1'b1);
    chk("postrst_steps", {bus.out_step_m, bus.out_step_n, bus.out_step_k}, '0);
    drain("postrst", 40, 1'b0);
    check_perf("postrst");

    // Random traffic against the model
    for (int c = 0; c < 500; c++) begin
      bus.in_valid  = ($urandom_range(2, 0) == 0);
      bus.in_wid    = WID_W'($urandom);
      bus.in_fmt_s  = 4'($urandom_range(13, 0));
      bus.in_fmt_d  = 4'($urandom_range(13, 0));
      bus.out_ready = ($urandom_range(9, 0) < 7);
      step();
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    drain("rand_tail", 100, 1'b0);
    step();
    check_perf("rand");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
